// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind uart_rx: first-word-fall-through FIFO with a
// valid/ready drain port and a sticky overflow flag for bytes lost while full.
module uart_rx_fifo #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                       uart_clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_strobe,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  input  logic                       overflow_clear
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         count_q, count_d;
  logic                  overflow_q, overflow_d;

  logic empty;
  logic is_full;
  logic do_read;
  logic do_write;
  logic do_drop;

  // MSB is the wrap bit: equal pointers mean empty, differing wrap bits mean full.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign is_full = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

  assign do_read  = !empty && out_ready;
  assign do_write = in_strobe && (!is_full || do_read);
  assign do_drop  = in_strobe && is_full && !do_read;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (do_write) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_read)  rd_ptr_d = rd_ptr_q + PW'(1);

    unique case ({do_write, do_read})
      2'b10:   count_d = count_q + PW'(1);
      2'b01:   count_d = count_q - PW'(1);
      default: count_d = count_q;
    endcase

    // A drop in the same cycle as a clear keeps the flag set.
    if (do_drop) begin
      overflow_d = 1'b1;
    end else if (overflow_clear) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge uart_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_write) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  assign out_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid = !empty;
  assign count     = count_q;
  assign full      = is_full;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed plus randomized bench for uart_rx_fifo, checked against a queue model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 8;

  logic          uart_clk;
  logic          reset;
  logic [DW-1:0] in_data;
  logic          in_strobe;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    count;
  logic          full;
  logic          overflow;
  logic          overflow_clear;

  int passed = 0;
  int total  = 0;

  logic [DW-1:0] model_q[$];
  logic          model_ovf = 1'b0;

  uart_rx_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DW)
  ) dut (
    .uart_clk       (uart_clk),
    .reset          (reset),
    .in_data        (in_data),
    .in_strobe      (in_strobe),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .count          (count),
    .full           (full),
    .overflow       (overflow),
    .overflow_clear (overflow_clear)
  );

  initial uart_clk = 1'b0;
  always #5 uart_clk = ~uart_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_state(input string tag);
    check({tag, ".valid"},    32'(out_valid), 32'(model_q.size() != 0));
    check({tag, ".count"},    32'(count),     32'(model_q.size()));
    check({tag, ".full"},     32'(full),      32'(model_q.size() == DEPTH));
    check({tag, ".overflow"}, 32'(overflow),  32'(model_ovf));
    if (model_q.size() != 0) check({tag, ".data"}, 32'(out_data), 32'(model_q[0]));
  endtask

  // Called at a falling edge: apply inputs, advance the model across the next
  // rising edge, then compare at the following falling edge.
  task automatic step(input string tag, input logic s, input logic [DW-1:0] d,
                      input logic rdy, input logic clr);
    logic rd;
    logic was_full;
    in_strobe      = s;
    in_data        = d;
    out_ready      = rdy;
    overflow_clear = clr;
    rd       = (model_q.size() != 0) && rdy;
    was_full = (model_q.size() == DEPTH);
    if (rd) void'(model_q.pop_front());
    if (s && (!was_full || rd)) model_q.push_back(d);
    if (s && was_full && !rd) model_ovf = 1'b1;
    else if (clr) model_ovf = 1'b0;
    @(posedge uart_clk);
    @(negedge uart_clk);
    in_strobe      = 1'b0;
    overflow_clear = 1'b0;
    check_state(tag);
  endtask

  initial begin
    logic [DW-1:0] bytes3 [3];
    bytes3[0] = 8'h55;
    bytes3[1] = 8'hA3;
    bytes3[2] = 8'h0F;

    reset          = 1'b0;
    in_data        = '0;
    in_strobe      = 1'b0;
    out_ready      = 1'b0;
    overflow_clear = 1'b0;
    repeat (3) @(negedge uart_clk);
    reset = 1'b1;
    repeat (5) @(negedge uart_clk);
    check_state("reset");
    check("reset.data_zero", 32'(out_data), 32'h0);

    // Ordering
    for (int i = 0; i < 3; i++) step("order_wr", 1'b1, bytes3[i], 1'b0, 1'b0);
    check("order.count3", 32'(count), 32'd3);
    check("order.head", 32'(out_data), 32'h55);
    for (int i = 0; i < 3; i++) begin
      check("order.rd", 32'(out_data), 32'(bytes3[i]));
      step("order_rd", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("order.empty", 32'(out_valid), 32'h0);

    // Fill, overflow, clear, read+write at full, clear-vs-drop
    for (int i = 0; i < 16; i++) step("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    check("fill.full", 32'(full), 32'h1);
    step("drop_ee", 1'b1, 8'hEE, 1'b0, 1'b0);
    check("drop.ovf", 32'(overflow), 32'h1);
    step("clr_alone", 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr.ovf0", 32'(overflow), 32'h0);
    check("rw_full.head", 32'(out_data), 32'h00);
    step("rw_full", 1'b1, 8'h77, 1'b1, 1'b0);
    check("rw_full.count", 32'(count), 32'd16);
    step("clr_drop", 1'b1, 8'hEE, 1'b0, 1'b1);
    check("clr_drop.ovf", 32'(overflow), 32'h1);
    for (int i = 1; i < 16; i++) begin
      check("drain.seq", 32'(out_data), 32'(i));
      step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain.last", 32'(out_data), 32'h77);
    step("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    step("clr", 1'b0, 8'h00, 1'b0, 1'b1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) step("load5", 1'b1, 8'($urandom), 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1;
    model_q.delete();
    model_ovf = 1'b0;
    check_state("async_rst");
    check("async_rst.data_zero", 32'(out_data), 32'h0);
    @(negedge uart_clk);
    reset = 1'b1;
    @(negedge uart_clk);
    step("post_rst_wr", 1'b1, 8'h3C, 1'b0, 1'b0);
    check("post_rst.head", 32'(out_data), 32'h3C);
    step("post_rst_rd", 1'b0, 8'h00, 1'b1, 1'b0);

    // Randomized traffic; alternating phases favour filling and draining
    for (int i = 0; i < 600; i++) begin
      logic s;
      logic rdy;
      logic clr;
      s   = ($urandom_range(0, 3) != 0);
      rdy = ((i / 60) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      step("random", s, 8'($urandom), rdy, clr);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer placed directly downstream of `uart_rx`. It captures every byte presented on the receiver's `data`/`data_out_strobe` pair and stores it in a first-word-fall-through FIFO. A valid/ready consumer drains the FIFO, so a busy consumer does not lose bytes while the line keeps running. Bytes that arrive with the FIFO full are dropped, and a sticky overflow flag records the loss.

## Interface
- `DEPTH`, default 16: number of byte slots; must be a power of two, ≥ 2.
- `DATA_WIDTH`, default 8: width of each stored word; matches the `uart_rx` data width.
- `uart_clk`, in, 1: single clock, the same clock as `uart_rx`.
- `reset`, in, 1: asynchronous, active-low reset; 0 resets all state immediately.
- `in_data`, in, DATA_WIDTH: byte from `uart_rx` `data`.
- `in_strobe`, in, 1: one-cycle pulse from `uart_rx` `data_out_strobe`; qualifies `in_data`.
- `out_data`, out, DATA_WIDTH: head-of-FIFO byte; meaningful only while `out_valid` = 1.
- `out_valid`, out, 1: FIFO non-empty.
- `out_ready`, in, 1: consumer accepts `out_data` this cycle.
- `count`, out, $clog2(DEPTH)+1: number of stored bytes, 0..DEPTH.
- `full`, out, 1: `count` == DEPTH.
- `overflow`, out, 1: sticky flag; a byte was dropped.
- `overflow_clear`, in, 1: synchronous clear of `overflow`.

## Operation
- **Storage:** register array `mem[DEPTH]`.
- **Pointers:** `wr_ptr` and `rd_ptr` are each $clog2(DEPTH)+1 bits; the MSB is the wrap bit. Increment modulo 2·DEPTH.
  - empty when the pointers are equal.
  - full when the low bits are equal and the MSBs differ.
- **Read handshake:** a read occurs when `out_valid && out_ready`; `rd_ptr` then increments.
- **Write:** a write occurs when `in_strobe && (!full || read)`. The byte goes to `mem[wr_ptr]` and `wr_ptr` increments.
- **Drop:** when `in_strobe && full && !read`, the byte is discarded, `overflow` is set to 1, and no pointers change.
- **Count:** `count` = `wr_ptr` − `rd_ptr` (modulo, width $clog2(DEPTH)+1). It is registered, and it is incremented or decremented together with the pointers.
- **Simultaneous read and write:**
  - FIFO non-empty: both are performed and `count` is unchanged.
  - FIFO full: the write is accepted, because the read frees the slot.
- **Empty with `in_strobe` and `out_ready`:** no read happens (`out_valid` = 0). The byte is written and appears at the output on the next cycle.
- **Overflow flag priority:** if `overflow_clear` and a new drop occur in the same cycle, set wins and `overflow` stays 1.
- **Output path:** `out_data` = `mem[rd_ptr[low bits]]` (combinational read from the register array). `out_valid` = !empty, derived from registered pointers.
- **Protocol:** `out_ready` may be held high continuously. `out_data` is stable while `out_valid` = 1 and no read occurs.
- **Reset (asynchronous, `reset` = 0):** clears both pointers, `count`, `overflow` and all `mem` entries to 0.
  - Any bytes held are discarded, including when reset is asserted mid-burst.
  - Inputs are ignored until `reset` = 1.

## Timing
- Reset values of outputs: `out_data` = 0, `out_valid` = 0, `count` = 0, `full` = 0, `overflow` = 0.
- **Write-to-valid latency:** 1 cycle. A strobe on edge N into an empty FIFO gives `out_valid` = 1 and `out_data` = byte after edge N.
- **Read:** data is consumed on the edge where `out_valid && out_ready`. The next byte (or `out_valid` = 0) appears after that same edge.
- **Full timing:** `full` and `count` update on the same edge as the pointer change. `overflow` rises on the edge of the dropped strobe.
- **Throughput:** one write and one read per cycle are sustained indefinitely.

## Test plan
- **Reset state:** assert reset, release it, idle 5 cycles → `out_valid` = 0, `count` = 0, `overflow` = 0, `out_data` = 0.
- **Ordering:** with `out_ready` = 0, strobe 0x55, 0xA3, 0x0F → `count` = 3. Then raise `out_ready` → reads return 0x55, 0xA3, 0x0F in consecutive cycles, then `out_valid` = 0 and `count` = 0.
- **Fill and overflow:**
  - With `out_ready` = 0, strobe 16 bytes 0x00..0x0F → `full` = 1, `count` = 16.
  - 17th strobe (0xEE) → `overflow` = 1, `count` = 16, 0xEE never read.
  - Drain → 0x00..0x0F in order, with correct wrap of the pointers.
- **Read and write at full:** with the FIFO full, strobe 0x77 in the same cycle as a read → read returns the old head, 0x77 is accepted, `count` stays 16, `overflow` stays 0.
- **Overflow clear:**
  - `overflow_clear` pulse alone → `overflow` returns to 0.
  - `overflow_clear` in the same cycle as a drop → `overflow` remains 1.
- **Reset mid-operation:** load 5 bytes, assert reset asynchronously between clock edges → outputs go to reset values immediately without a clock. After release, a new byte 0x3C is read back as the first byte.
